vdp_vram_arbiter: RTL and testbench

//  Single-port VRAM arbiter for the VDP. Shares one synchronous VRAM between three requesters:
//  - background tile fetcher (bg)
//  - sprite engine (spr)
//  - CPU data port (cpu)

---
 rtl/vdp_vram_arbiter.sv | 125 ++++++++++++
 tb/tb_vdp_vram_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: bg / spr / cpu share one synchronous VRAM, with raster-phase priority.
// Latency: grant is combinational in cycle N, the VRAM access is registered at the end of N, and the tagged rvalid comes back in N+2.
// Backpressure: a requester holds req until its gnt; the cpu is forced to top priority after CPU_MAX_WAIT lost cycles.
module vdp_vram_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int HBLANK_X     = 256,
   parameter int CPU_MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [8:0]        pixel_x,
   input  logic              bg_req,
   input  logic [ADDR_W-1:0] bg_addr,
   output logic              bg_gnt,
   output logic              bg_rvalid,
   input  logic              spr_req,
   input  logic [ADDR_W-1:0] spr_addr,
   output logic              spr_gnt,
   output logic              spr_rvalid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [7:0]        rdata,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [7:0]        vram_wdata,
   input  logic [7:0]        vram_rdata
);

   localparam int         CNT_W      = $clog2(CPU_MAX_WAIT) + 1;
   localparam logic [9:0] HBLANK_X_W = 10'(HBLANK_X);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_MAX_WAIT);

   typedef enum logic [1:0] {TAG_NONE, TAG_BG, TAG_SPR, TAG_CPU} tag_e;
   typedef enum logic {PH_ACTIVE, PH_HBLANK} phase_e;

   phase_e            phase_q, phase_d;
   tag_e              tag1_q, tag1_d, tag2_q, tag2_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
   logic              vram_we_q, vram_we_d;
   logic [7:0]        vram_wdata_q, vram_wdata_d;
   logic              starve;

   assign starve = (wait_cnt_q == CNT_MAX);

   // Grant selection: starvation override first, then phase-dependent fixed priority
   always_comb begin
      bg_gnt  = 1'b0;
      spr_gnt = 1'b0;
      cpu_gnt = 1'b0;
      if (!rst_n) begin
         // no grants while reset is asserted
      end else if (starve && cpu_req) begin
         cpu_gnt = 1'b1;
      end else if (phase_q == PH_ACTIVE) begin
         if (bg_req)       bg_gnt  = 1'b1;
         else if (spr_req) spr_gnt = 1'b1;
         else if (cpu_req) cpu_gnt = 1'b1;
      end else begin
         if (spr_req)      spr_gnt = 1'b1;
         else if (bg_req)  bg_gnt  = 1'b1;
         else if (cpu_req) cpu_gnt = 1'b1;
      end
   end

   // Next-state: VRAM command, owner tag pipeline, raster phase and cpu wait counter
   always_comb begin
      vram_addr_d  = vram_addr_q;
      vram_we_d    = 1'b0;
      vram_wdata_d = vram_wdata_q;
      tag1_d       = TAG_NONE;
      if (bg_gnt) begin
         vram_addr_d = bg_addr;
         tag1_d      = TAG_BG;
      end else if (spr_gnt) begin
         vram_addr_d = spr_addr;
         tag1_d      = TAG_SPR;
      end else if (cpu_gnt) begin
         vram_addr_d = cpu_addr;
         vram_we_d   = cpu_we;
         if (cpu_we) vram_wdata_d = cpu_wdata;
         // writes return nothing, so they travel as NONE
         tag1_d = cpu_we ? TAG_NONE : TAG_CPU;
      end
      tag2_d  = tag1_q;
      phase_d = ({1'b0, pixel_x} >= HBLANK_X_W) ? PH_HBLANK : PH_ACTIVE;
      if (!cpu_req || cpu_gnt)     wait_cnt_d = '0;
      else if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
      else                         wait_cnt_d = wait_cnt_q;
   end

   // State registers with synchronous active-low reset; in-flight reads are dropped
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q      <= PH_ACTIVE;
         tag1_q       <= TAG_NONE;
         tag2_q       <= TAG_NONE;
         wait_cnt_q   <= '0;
         vram_addr_q  <= '0;
         vram_we_q    <= 1'b0;
         vram_wdata_q <= '0;
      end else begin
         phase_q      <= phase_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag2_d;
         wait_cnt_q   <= wait_cnt_d;
         vram_addr_q  <= vram_addr_d;
         vram_we_q    <= vram_we_d;
         vram_wdata_q <= vram_wdata_d;
      end
   end

   assign bg_rvalid  = (tag2_q == TAG_BG);
   assign spr_rvalid = (tag2_q == TAG_SPR);
   assign cpu_rvalid = (tag2_q == TAG_CPU);
   assign rdata      = vram_rdata;
   assign vram_addr  = vram_addr_q;
   assign vram_we    = vram_we_q;
   assign vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter with a synchronous VRAM model.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
// All expectations are hand-derived constants or come from the bench's own memory contents.
module tb_vdp_vram_arbiter;

   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [8:0]        pixel_x;
   logic              bg_req, spr_req, cpu_req, cpu_we;
   logic [ADDR_W-1:0] bg_addr, spr_addr, cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              bg_gnt, spr_gnt, cpu_gnt;
   logic              bg_rvalid, spr_rvalid, cpu_rvalid;
   logic [7:0]        rdata;
   logic [ADDR_W-1:0] vram_addr;
   logic              vram_we;
   logic [7:0]        vram_wdata;
   logic [7:0]        vram_rdata;

   logic [7:0] mem [0:(1<<ADDR_W)-1];

   int n_cmp = 0;
   int n_err = 0;

   vdp_vram_arbiter #(.ADDR_W(ADDR_W), .HBLANK_X(256), .CPU_MAX_WAIT(16)) dut (
      .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x),
      .bg_req(bg_req), .bg_addr(bg_addr), .bg_gnt(bg_gnt), .bg_rvalid(bg_rvalid),
      .spr_req(spr_req), .spr_addr(spr_addr), .spr_gnt(spr_gnt), .spr_rvalid(spr_rvalid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .rdata(rdata),
      .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
   );

   always #5 clk = ~clk;

   // synchronous single-port VRAM, read-before-write, one cycle latency
   always @(posedge clk) begin
      if (vram_we) mem[vram_addr] <= vram_wdata;
      vram_rdata <= mem[vram_addr];
   end

   function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bg_req = 0; spr_req = 0; cpu_req = 0; cpu_we = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pat(ADDR_W'(i));
      mem[14'h1234] = 8'h5A;
      vram_rdata = 8'h00;
      rst_n = 0; pixel_x = 0;
      bg_req = 0; spr_req = 0; cpu_req = 0; cpu_we = 0;
      bg_addr = 0; spr_addr = 0; cpu_addr = 0; cpu_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      // reset state
      bg_req = 1; spr_req = 1; cpu_req = 1;
      smp();
      chk("rst_gnt", 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'h0);
      chk("rst_rvalid", 32'({bg_rvalid, spr_rvalid, cpu_rvalid}), 32'h0);
      chk("rst_vram", 32'({vram_addr, vram_we, vram_wdata}), 32'h0);
      tick();
      bg_req = 0; spr_req = 0; cpu_req = 0;
      rst_n = 1;
      tick();

      // 1: lone cpu read
      cpu_req = 1; cpu_we = 0; cpu_addr = 14'h1234;
      smp();
      chk("t1_gnt", 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'b001);
      tick();
      cpu_req = 0;
      smp();
      chk("t1_vaddr", 32'(vram_addr), 32'h1234);
      chk("t1_vwe", 32'(vram_we), 32'h0);
      chk("t1_early_rv", 32'(cpu_rvalid), 32'h0);
      tick();
      smp();
      chk("t1_rvalid", 32'({bg_rvalid, spr_rvalid, cpu_rvalid}), 32'b001);
      chk("t1_rdata", 32'(rdata), 32'h5A);
      tick();
      smp();
      chk("t1_rv_end", 32'(cpu_rvalid), 32'h0);
      idle(2);

      // 2: active line, bg beats spr, 20 back-to-back bg reads
      pixel_x = 100;
      for (int i = 0; i < 22; i++) begin
         bg_req = (i < 20); spr_req = (i < 20);
         bg_addr = ADDR_W'(14'h0200 + i); spr_addr = 14'h0300;
         smp();
         if (i < 20) chk($sformatf("t2_gnt%0d", i), 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'b100);
         chk($sformatf("t2_sprrv%0d", i), 32'(spr_rvalid), 32'h0);
         if (i >= 2) begin
            chk($sformatf("t2_bgrv%0d", i), 32'(bg_rvalid), 32'h1);
            chk($sformatf("t2_rd%0d", i), 32'(rdata), 32'(pat(ADDR_W'(14'h0200 + i - 2))));
         end
         tick();
      end
      idle(2);

      // 3: hblank, phase takes effect one cycle after pixel_x changes
      pixel_x = 300; bg_req = 1; spr_req = 1; bg_addr = 14'h0010; spr_addr = 14'h0020;
      smp();
      chk("t3_oldphase", 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'b100);
      for (int i = 0; i < 4; i++) begin
         tick();
         smp();
         chk($sformatf("t3_spr%0d", i), 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'b010);
      end
      tick();
      spr_req = 0;
      smp();
      chk("t3_bg_after", 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'b100);
      chk("t3_vaddr", 32'(vram_addr), 32'h0020);
      tick();
      smp();
      chk("t3_rv_spr", 32'({bg_rvalid, spr_rvalid, cpu_rvalid}), 32'b010);
      chk("t3_rd_spr", 32'(rdata), 32'(pat(14'h0020)));
      idle(1);
      pixel_x = 50;
      idle(3);

      // 4: cpu starvation guard under continuous bg traffic
      bg_req = 1; bg_addr = 14'h0040; cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0050;
      for (int c = 0; c < 16; c++) begin
         smp();
         chk($sformatf("t4_bg%0d", c), 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'b100);
         tick();
      end
      smp();
      chk("t4_cpu16", 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'b001);
      tick();
      cpu_req = 0;
      smp();
      chk("t4_bg17", 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'b100);
      chk("t4_vaddr", 32'(vram_addr), 32'h0050);
      tick();
      cpu_req = 1;
      smp();
      chk("t4_cnt_clr", 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'b100);
      chk("t4_cpu_rv", 32'({bg_rvalid, spr_rvalid, cpu_rvalid}), 32'b001);
      chk("t4_cpu_rd", 32'(rdata), 32'(pat(14'h0050)));
      idle(4);

      // 5: cpu write then read-back
      cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0ABC; cpu_wdata = 8'h77;
      smp();
      chk("t5_wgnt", 32'(cpu_gnt), 32'h1);
      tick();
      cpu_we = 0; cpu_wdata = 8'h00;
      smp();
      chk("t5_rgnt", 32'(cpu_gnt), 32'h1);
      chk("t5_we", 32'(vram_we), 32'h1);
      chk("t5_waddr", 32'(vram_addr), 32'h0ABC);
      chk("t5_wdata", 32'(vram_wdata), 32'h77);
      tick();
      cpu_req = 0;
      smp();
      chk("t5_we_off", 32'(vram_we), 32'h0);
      chk("t5_no_wr_rv", 32'({bg_rvalid, spr_rvalid, cpu_rvalid}), 32'h0);
      tick();
      smp();
      chk("t5_rv", 32'(cpu_rvalid), 32'h1);
      chk("t5_rd", 32'(rdata), 32'h77);
      idle(3);

      // 6: read in flight across a one-cycle reset is dropped
      bg_req = 1; bg_addr = 14'h0100;
      smp();
      chk("t6_gnt", 32'(bg_gnt), 32'h1);
      tick();
      bg_req = 0; rst_n = 0;
      smp();
      chk("t6_rv_n1", 32'(bg_rvalid), 32'h0);
      tick();
      rst_n = 1;
      smp();
      chk("t6_rv_n2", 32'({bg_rvalid, spr_rvalid, cpu_rvalid}), 32'h0);
      chk("t6_vram", 32'({vram_addr, vram_we, vram_wdata}), 32'h0);
      chk("t6_gnt_off", 32'({bg_gnt, spr_gnt, cpu_gnt}), 32'h0);
      tick();
      smp();
      chk("t6_rv_n3", 32'(bg_rvalid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
